// File: rtl/pipe_wb_stage.sv
// MEM->WB pipeline register chain with per-stage valid, stall/flush control,
// write-back data select, WB->ID forwarding compare and a retire counter.
// Only the last stage is visible at the ports; intermediate stages never forward.
module pipe_wb_stage #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RN_W    = 5,
   parameter int unsigned STAGES  = 1,
   parameter int unsigned CNT_W   = 16,
   parameter bit          ZERO_RN = 1'b1
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              in_wreg,
   input  logic              in_m2reg,
   input  logic [DATA_W-1:0] in_mo,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [RN_W-1:0]   in_rn,
   input  logic [RN_W-1:0]   q_rs,
   input  logic [RN_W-1:0]   q_rt,
   output logic              out_valid,
   output logic              out_wreg,
   output logic              out_m2reg,
   output logic [DATA_W-1:0] out_mo,
   output logic [DATA_W-1:0] out_alu,
   output logic [RN_W-1:0]   out_rn,
   output logic [DATA_W-1:0] out_wdata,
   output logic              fwd_rs_hit,
   output logic              fwd_rt_hit,
   output logic [CNT_W-1:0]  retire_cnt
);

   localparam int unsigned LAST = STAGES - 1;

   logic [STAGES-1:0]             valid_q, valid_d;
   logic [STAGES-1:0]             wreg_q,  wreg_d;
   logic [STAGES-1:0]             m2reg_q, m2reg_d;
   logic [STAGES-1:0][DATA_W-1:0] mo_q,    mo_d;
   logic [STAGES-1:0][DATA_W-1:0] alu_q,   alu_d;
   logic [STAGES-1:0][RN_W-1:0]   rn_q,    rn_d;
   logic [CNT_W-1:0]              cnt_q,   cnt_d;

   // Next-state of the chain: flush clears control bits only, stall holds, otherwise shift.
   // A bubble still captures its data fields but never carries wreg/m2reg.
   always_comb begin
      valid_d = valid_q;
      wreg_d  = wreg_q;
      m2reg_d = m2reg_q;
      mo_d    = mo_q;
      alu_d   = alu_q;
      rn_d    = rn_q;
      if (flush) begin
         valid_d = '0;
         wreg_d  = '0;
         m2reg_d = '0;
      end else if (!stall) begin
         for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            wreg_d[k]  = wreg_q[k-1];
            m2reg_d[k] = m2reg_q[k-1];
            mo_d[k]    = mo_q[k-1];
            alu_d[k]   = alu_q[k-1];
            rn_d[k]    = rn_q[k-1];
         end
         valid_d[0] = in_valid;
         wreg_d[0]  = in_valid & in_wreg;
         m2reg_d[0] = in_valid & in_m2reg;
         mo_d[0]    = in_mo;
         alu_d[0]   = in_alu;
         rn_d[0]    = in_rn;
      end
   end

   // Stage registers; reset drops everything in flight.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         valid_q <= '0;
         wreg_q  <= '0;
         m2reg_q <= '0;
         mo_q    <= '0;
         alu_q   <= '0;
         rn_q    <= '0;
      end else begin
         valid_q <= valid_d;
         wreg_q  <= wreg_d;
         m2reg_q <= m2reg_d;
         mo_q    <= mo_d;
         alu_q   <= alu_d;
         rn_q    <= rn_d;
      end
   end

   // A last-stage entry retires whenever the chain is not stalled, even if flushed,
   // because it was already presented to the register file that cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (valid_q[LAST] && !stall) cnt_d = cnt_q + CNT_W'(1);
   end

   // Retire counter, wraps naturally.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign out_valid  = valid_q[LAST];
   assign out_m2reg  = m2reg_q[LAST];
   assign out_mo     = mo_q[LAST];
   assign out_alu    = alu_q[LAST];
   assign out_rn     = rn_q[LAST];
   assign out_wdata  = m2reg_q[LAST] ? mo_q[LAST] : alu_q[LAST];
   assign out_wreg   = valid_q[LAST] & wreg_q[LAST] & ~(ZERO_RN & (rn_q[LAST] == '0));
   assign fwd_rs_hit = out_wreg & (rn_q[LAST] == q_rs) & ~(ZERO_RN & (q_rs == '0));
   assign fwd_rt_hit = out_wreg & (rn_q[LAST] == q_rt) & ~(ZERO_RN & (q_rt == '0));
   assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_wb_stage.sv
// Bench for pipe_wb_stage: a 1-stage/16-bit-counter instance and a 3-stage/4-bit-counter
// instance share one stimulus stream and are compared against a queue-based pipeline model.
module tb_pipe_wb_stage;

   logic        clock = 1'b0;
   logic        resetn;
   logic        stall, flush, in_valid, in_wreg, in_m2reg;
   logic [31:0] in_mo, in_alu;
   logic [4:0]  in_rn, q_rs, q_rt;

   logic        o1_valid, o1_wreg, o1_m2reg, o1_rs, o1_rt;
   logic [31:0] o1_mo, o1_alu, o1_wdata;
   logic [4:0]  o1_rn;
   logic [15:0] o1_cnt;

   logic        o3_valid, o3_wreg, o3_m2reg, o3_rs, o3_rt;
   logic [31:0] o3_mo, o3_alu, o3_wdata;
   logic [4:0]  o3_rn;
   logic [3:0]  o3_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   pipe_wb_stage #(.DATA_W(32), .RN_W(5), .STAGES(1), .CNT_W(16), .ZERO_RN(1'b1)) u_s1 (
      .clock(clock), .resetn(resetn), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_wreg(in_wreg), .in_m2reg(in_m2reg),
      .in_mo(in_mo), .in_alu(in_alu), .in_rn(in_rn), .q_rs(q_rs), .q_rt(q_rt),
      .out_valid(o1_valid), .out_wreg(o1_wreg), .out_m2reg(o1_m2reg),
      .out_mo(o1_mo), .out_alu(o1_alu), .out_rn(o1_rn), .out_wdata(o1_wdata),
      .fwd_rs_hit(o1_rs), .fwd_rt_hit(o1_rt), .retire_cnt(o1_cnt));

   pipe_wb_stage #(.DATA_W(32), .RN_W(5), .STAGES(3), .CNT_W(4), .ZERO_RN(1'b1)) u_s3 (
      .clock(clock), .resetn(resetn), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_wreg(in_wreg), .in_m2reg(in_m2reg),
      .in_mo(in_mo), .in_alu(in_alu), .in_rn(in_rn), .q_rs(q_rs), .q_rt(q_rt),
      .out_valid(o3_valid), .out_wreg(o3_wreg), .out_m2reg(o3_m2reg),
      .out_mo(o3_mo), .out_alu(o3_alu), .out_rn(o3_rn), .out_wdata(o3_wdata),
      .fwd_rs_hit(o3_rs), .fwd_rt_hit(o3_rt), .retire_cnt(o3_cnt));

   wire [121:0] act1 = {o1_valid, o1_wreg, o1_m2reg, o1_mo, o1_alu, o1_rn, o1_wdata,
                        o1_rs, o1_rt, o1_cnt};
   wire [121:0] act3 = {o3_valid, o3_wreg, o3_m2reg, o3_mo, o3_alu, o3_rn, o3_wdata,
                        o3_rs, o3_rt, 12'h000, o3_cnt};

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        valid;
      logic        wreg;
      logic        m2reg;
      logic [31:0] mo;
      logic [31:0] alu;
      logic [4:0]  rn;
   } ent_t;

   ent_t m1[$];
   ent_t m3[$];
   int   cnt1, cnt3;

   task automatic model_reset();
      m1 = {};
      m3 = {};
      m1.push_back('0);
      for (int i = 0; i < 3; i++) m3.push_back('0);
      cnt1 = 0;
      cnt3 = 0;
   endtask

   task automatic model_edge();
      ent_t e;
      e.valid = in_valid;
      e.wreg  = in_valid & in_wreg;
      e.m2reg = in_valid & in_m2reg;
      e.mo    = in_mo;
      e.alu   = in_alu;
      e.rn    = in_rn;
      if (m1[$].valid && !stall) cnt1++;
      if (m3[$].valid && !stall) cnt3++;
      if (flush) begin
         foreach (m1[i]) begin m1[i].valid = 1'b0; m1[i].wreg = 1'b0; m1[i].m2reg = 1'b0; end
         foreach (m3[i]) begin m3[i].valid = 1'b0; m3[i].wreg = 1'b0; m3[i].m2reg = 1'b0; end
      end else if (!stall) begin
         m1.push_front(e); void'(m1.pop_back());
         m3.push_front(e); void'(m3.pop_back());
      end
   endtask

   function automatic logic [121:0] exp_vec(ent_t l, int cnt, int cw);
      logic        wr, fr, ft;
      logic [15:0] c;
      wr = l.valid && l.wreg && (l.rn != 5'd0);
      fr = wr && (l.rn == q_rs) && (q_rs != 5'd0);
      ft = wr && (l.rn == q_rt) && (q_rt != 5'd0);
      c  = 16'(cnt % (1 << cw));
      return {l.valid, wr, l.m2reg, l.mo, l.alu, l.rn, (l.m2reg ? l.mo : l.alu), fr, ft, c};
   endfunction

   // ---------------- stimulus primitives ----------------
   task automatic drive(input logic v, input logic w, input logic m, input logic [31:0] mo,
                        input logic [31:0] alu, input logic [4:0] rn,
                        input logic st, input logic fl);
      in_valid = v; in_wreg = w; in_m2reg = m; in_mo = mo; in_alu = alu; in_rn = rn;
      stall = st; flush = fl;
   endtask

   task automatic bubble();
      drive(1'b0, 1'b0, 1'b0, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (act1 !== 122'd0) begin
         n_fail++; $display("FAIL reset_s1 got=%h exp=0", act1);
      end
      n_checks++;
      if (act3 !== 122'd0) begin
         n_fail++; $display("FAIL reset_s3 got=%h exp=0", act3);
      end
      @(negedge clock);
      resetn = 1'b1;
      bubble();
   endtask

   task automatic random_cycle(input string tag, input int cyc, input bit allow_ctl);
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom, $urandom, 5'($urandom_range(0, 7)),
            allow_ctl && ($urandom_range(0, 6) == 0), allow_ctl && ($urandom_range(0, 9) == 0));
      q_rs = 5'($urandom_range(0, 7));
      q_rt = 5'($urandom_range(0, 7));
      tick();
      n_checks++;
      if (act1 !== exp_vec(m1[$], cnt1, 16)) begin
         n_fail++; $display("FAIL %s_s1 cyc=%0d got=%h exp=%h", tag, cyc, act1, exp_vec(m1[$], cnt1, 16));
      end
      n_checks++;
      if (act3 !== exp_vec(m3[$], cnt3, 4)) begin
         n_fail++; $display("FAIL %s_s3 cyc=%0d got=%h exp=%h", tag, cyc, act3, exp_vec(m3[$], cnt3, 4));
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 8; i++) random_cycle("pre_reset", i, 1'b0);
      // asynchronous reset in the middle of a cycle, with valid entries in flight
      do_reset();
      tick();
      n_checks++;
      if (o3_cnt !== 4'd0 || o1_cnt !== 16'd0) begin
         n_fail++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", o1_cnt, o3_cnt);
      end
   endtask

   task automatic test_pass_through();
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 5'd5, 1'b0, 1'b0);
      tick();
      n_checks++;
      if ({o1_valid, o1_wreg, o1_rn, o1_wdata} !== {1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL pass_mo got=%b %b %0d %h exp=1 1 5 deadbeef", o1_valid, o1_wreg, o1_rn, o1_wdata);
      end
      n_checks++;
      if (o3_valid !== 1'b0) begin
         n_fail++; $display("FAIL pass_s3_early got=%b exp=0", o3_valid);
      end
      drive(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 5'd5, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (o1_wdata !== 32'h0000_1234 || o1_wreg !== 1'b1) begin
         n_fail++; $display("FAIL pass_alu got=%h wreg=%b exp=00001234 wreg=1", o1_wdata, o1_wreg);
      end
   endtask

   task automatic test_stall_latency();
      logic       v_sch[7]  = '{1, 1, 1, 1, 0, 0, 0};
      logic [4:0] rn_sch[7] = '{1, 2, 2, 3, 0, 0, 0};
      logic       st_sch[7] = '{0, 1, 0, 0, 0, 0, 0};
      logic       ov_exp[7] = '{0, 0, 0, 1, 1, 1, 0};
      logic [4:0] rn_exp[7] = '{0, 0, 0, 1, 2, 3, 0};
      do_reset();
      for (int e = 0; e < 7; e++) begin
         drive(v_sch[e], 1'b1, 1'b0, $urandom, $urandom, rn_sch[e], st_sch[e], 1'b0);
         tick();
         n_checks++;
         if (o3_valid !== ov_exp[e] || (ov_exp[e] && o3_rn !== rn_exp[e])) begin
            n_fail++;
            $display("FAIL latency edge=%0d got=v%b rn%0d exp=v%b rn%0d", e + 1, o3_valid, o3_rn, ov_exp[e], rn_exp[e]);
         end
         n_checks++;
         if (act1 !== exp_vec(m1[$], cnt1, 16)) begin
            n_fail++; $display("FAIL latency_s1 edge=%0d got=%h exp=%h", e + 1, act1, exp_vec(m1[$], cnt1, 16));
         end
      end
      n_checks++;
      if (o3_cnt !== 4'd3) begin
         n_fail++; $display("FAIL latency_cnt got=%0d exp=3", o3_cnt);
      end
   endtask

   task automatic test_flush_stall();
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 32'h1, 32'hA, 5'd9, 1'b0, 1'b0);  tick();
      drive(1'b1, 1'b1, 1'b0, 32'h2, 32'hB, 5'd10, 1'b0, 1'b0); tick();
      bubble(); tick();
      n_checks++;
      if (o3_valid !== 1'b1 || o3_rn !== 5'd9) begin
         n_fail++; $display("FAIL flush_pre got=v%b rn%0d exp=v1 rn9", o3_valid, o3_rn);
      end
      drive(1'b1, 1'b1, 1'b1, 32'h3, 32'hC, 5'd11, 1'b1, 1'b1);
      tick();
      n_checks++;
      if (o3_valid !== 1'b0 || o3_wreg !== 1'b0 || o3_cnt !== 4'd0) begin
         n_fail++; $display("FAIL flush_post got=v%b w%b cnt%0d exp=v0 w0 cnt0", o3_valid, o3_wreg, o3_cnt);
      end
      n_checks++;
      if (act1 !== exp_vec(m1[$], cnt1, 16)) begin
         n_fail++; $display("FAIL flush_s1 got=%h exp=%h", act1, exp_vec(m1[$], cnt1, 16));
      end
      for (int i = 0; i < 3; i++) begin
         bubble(); tick();
         n_checks++;
         if (o3_valid !== 1'b0 || o3_cnt !== 4'd0) begin
            n_fail++; $display("FAIL flush_drain i=%0d got=v%b cnt%0d exp=v0 cnt0", i, o3_valid, o3_cnt);
         end
      end
   endtask

   task automatic test_forwarding();
      do_reset();
      q_rs = 5'd7; q_rt = 5'd0;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h77, 5'd7, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (o1_rs !== 1'b1 || o1_rt !== 1'b0) begin
         n_fail++; $display("FAIL fwd_rn7 got=rs%b rt%b exp=rs1 rt0", o1_rs, o1_rt);
      end
      q_rt = 5'd7; stall = 1'b1; flush = 1'b1;
      #1;
      n_checks++;
      if (o1_rs !== 1'b1 || o1_rt !== 1'b1) begin
         n_fail++; $display("FAIL fwd_comb got=rs%b rt%b exp=rs1 rt1", o1_rs, o1_rt);
      end
      q_rs = 5'd0; q_rt = 5'd3;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 5'd0, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (o1_wreg !== 1'b0 || o1_rs !== 1'b0 || o1_valid !== 1'b1) begin
         n_fail++; $display("FAIL fwd_rn0 got=v%b w%b rs%b exp=v1 w0 rs0", o1_valid, o1_wreg, o1_rs);
      end
   endtask

   task automatic test_counter_wrap();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
               5'($urandom_range(0, 31)), 1'b0, 1'b0);
         tick();
      end
      for (int i = 0; i < 3; i++) begin bubble(); tick(); end
      n_checks++;
      if (o3_cnt !== 4'd1) begin
         n_fail++; $display("FAIL wrap_s3 got=%0d exp=1", o3_cnt);
      end
      n_checks++;
      if (o1_cnt !== 16'd17) begin
         n_fail++; $display("FAIL wrap_s1 got=%0d exp=17", o1_cnt);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) random_cycle("rand", i, 1'b1);
   endtask

   initial begin
      resetn = 1'b0;
      q_rs = '0; q_rt = '0;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      model_reset();
      @(negedge clock);
      test_reset();
      test_pass_through();
      test_stall_latency();
      test_flush_stall();
      test_forwarding();
      test_counter_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
